// File: rtl/onehot_index_scanner_pkg.sv
// rtl/onehot_index_scanner_pkg.sv - shared cache constants and scanner state encoding
package onehot_index_scanner_pkg;

    localparam int VEC_W = 64;
    localparam int IDX_W = 6;

    typedef enum logic {
        SCAN_IDLE   = 1'b0,
        SCAN_ACTIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/onehot_index_scanner_pri_enc64.sv
// rtl/onehot_index_scanner_pri_enc64.sv - lowest-set-bit encoder, inverse of the 6-to-64 line-select decoder
module pri_enc64
    import onehot_index_scanner_pkg::*;
(
    input  logic [VEC_W-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Walk from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/onehot_index_scanner.sv
// rtl/onehot_index_scanner.sv - streams the ascending indices of a multi-hot line vector, one per handshake
module onehot_index_scanner
    import onehot_index_scanner_pkg::*;
#(
    parameter int P_VEC_W = onehot_index_scanner_pkg::VEC_W,
    parameter int P_IDX_W = onehot_index_scanner_pkg::IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [P_VEC_W-1:0]   vec_in,
    input  logic                 abort,
    output logic                 busy,
    output logic                 idx_valid,
    output logic [P_IDX_W-1:0]   idx_out,
    input  logic                 idx_ready,
    output logic                 last,
    output logic                 done,
    output logic [P_IDX_W:0]     count_out
);

    localparam logic [P_VEC_W-1:0] VEC_ONE = P_VEC_W'(1);
    localparam logic [P_IDX_W:0]   CNT_ONE = (P_IDX_W + 1)'(1);

    scan_state_t          r_state;
    logic [P_VEC_W-1:0]   r_pending;
    logic [P_IDX_W:0]     r_count;
    logic                 r_done;

    logic [P_IDX_W-1:0]   w_idx;
    logic                 w_any;
    logic [P_VEC_W-1:0]   w_pending_dec;
    logic                 w_last;
    logic                 w_active;
    logic                 w_xfer;

    pri_enc64 u_pri_enc (
        .i_vec (r_pending),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // pending & (pending-1) clears the lowest set bit, i.e. the one on idx_out.
    assign w_pending_dec = r_pending - VEC_ONE;
    assign w_last        = ((r_pending & w_pending_dec) == '0) && w_any;
    assign w_active      = (r_state == SCAN_ACTIVE);
    assign w_xfer        = w_active && idx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SCAN_IDLE;
            r_pending <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state   <= SCAN_IDLE;
                r_pending <= '0;
            end else begin
                case (r_state)
                    SCAN_IDLE: begin
                        if (start) begin
                            r_count <= '0;
                            if (vec_in != '0) begin
                                r_pending <= vec_in;
                                r_state   <= SCAN_ACTIVE;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    SCAN_ACTIVE: begin
                        if (w_xfer) begin
                            r_pending <= r_pending & w_pending_dec;
                            r_count   <= r_count + CNT_ONE;
                            if (w_last) begin
                                r_state <= SCAN_IDLE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state   <= SCAN_IDLE;
                        r_pending <= '0;
                    end
                endcase
            end
        end
    end

    assign busy      = w_active;
    assign idx_valid = w_active;
    assign idx_out   = w_active ? w_idx : '0;
    assign last      = w_active && w_last;
    assign done      = r_done;
    assign count_out = r_count;

endmodule

// File: doc/onehot_index_scanner.md
Name: onehot_index_scanner

Overview:
- Inverse companion of the cache phase-3 6-to-64 one-hot line-select decoder.
- Takes a 64-bit multi-hot line vector (valid, dirty or hit bits) and returns the 6-bit index of each set bit, one per handshake, in ascending order.
- Used by the cache controller for flush/writeback walks and for victim index recovery from one-hot select vectors.

Parameters:
- VEC_W, 64, width of the input bit vector.
- IDX_W, 6, index width; must equal clog2(VEC_W).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  latch vec_in and begin a scan; honoured only in IDLE.
- vec_in  in  VEC_W  bit vector to scan; sampled when start is accepted.
- abort  in  1  cancel the scan in progress.
- busy  out  1  high while in SCAN.
- idx_valid  out  1  idx_out holds a valid index.
- idx_out  out  IDX_W  index of the lowest set bit still pending.
- idx_ready  in  1  consumer accepts idx_out.
- last  out  1  qualifies idx_out as the final index of this scan.
- done  out  1  one-cycle pulse when a scan completes normally.
- count_out  out  IDX_W+1  number of indices accepted in the current/last scan.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pending=0, count_out=0, done=0. Hence busy=0, idx_valid=0, idx_out=0, last=0.
- States are IDLE and SCAN.
- IDLE:
  - start=1 with vec_in!=0: pending<=vec_in, count_out<=0, go to SCAN. idx_valid rises the next cycle, so first-index latency is 1 cycle.
  - start=1 with vec_in==0: stay IDLE, count_out<=0, done=1 the next cycle.
- SCAN:
  - idx_valid=1.
  - idx_out = lowest set bit index of pending (combinational from the register).
  - last=1 iff pending has exactly one bit set.
- Handshake: transfer occurs when idx_valid&&idx_ready.
  - On transfer: clear bit idx_out in pending; count_out<=count_out+1.
  - If last was 1: go to IDLE and pulse done the next cycle.
  - While idx_ready=0, idx_out, last and pending hold stable.
- Back-to-back: one index per cycle when idx_ready is held high. A vector with N set bits completes in N cycles after entry to SCAN.
- start while busy is ignored, with no effect on pending or count_out.
- abort (any state): next cycle state=IDLE, pending=0, no done pulse, count_out holds the value reached.
  - abort has priority over a same-cycle transfer and over start.
- Wrap-around: count_out reaches 64 maximum (7 bits), so no overflow. Bit 63 is scanned last; idx_out=63 is legal.
- idx_out is 0 whenever idx_valid=0.
- done never coincides with idx_valid.
- Reset mid-scan drops everything immediately; no done pulse.

Decomposition:
- Shared cache package:
  - constants VEC_W=64, IDX_W=6.
  - state enum SCAN_IDLE/SCAN_ACTIVE.
- One sub-module: pri_enc64, a combinational lowest-set-bit encoder (64-bit in, 6-bit index, any flag). It is the logical inverse of the decoder and is reusable by hit-way encoding.
- "last" is computed as (pending & (pending-1))==0 && pending!=0.

Test Plan:
- Reset then idle: all outputs 0; start with vec_in=64'h0 -> done=1 exactly one cycle later, count_out=0, idx_valid never rises.
- Single bit: vec_in=64'h8000_0000_0000_0000 with idx_ready=1 -> idx_out=63, last=1 for one cycle; done next cycle; count_out=1.
- Multi-bit streaming: vec_in=64'h0000_0000_0000_0115 with idx_ready=1 -> idx_out=0,2,4,8 on consecutive cycles, last on 8, count_out=4.
- Backpressure: vec_in=64'h0000_0001_0000_0002 with idx_ready low for 3 cycles -> idx_out=1 is held stable; after release 1 then 32, last on 32.
- Abort: vec_in=64'hFFFF_FFFF_FFFF_FFFF, abort after 5 transfers -> IDLE next cycle, no done, count_out=5; a start asserted during busy is ignored.
- Async reset mid-scan: assert rst_n=0 between clock edges while idx_valid=1 -> all outputs drop to 0 immediately; a fresh scan after release behaves normally.
